// File: rtl/safecrackpro_pkg.sv
// safecrackpro_pkg: shared types for the safe's button front end.
//   N_BTN      : number of board keys / width of a btn code
//   btn_t      : one btn code (1 = key pressed, logical polarity)
//   fe_state_t : front-end FSM states, one-hot like the lock FSM
package safecrackpro_pkg;

    localparam int N_BTN = 4;

    typedef logic [N_BTN-1:0] btn_t;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        PRESS_DB = 4'b0010,
        HELD     = 4'b0100,
        REL_DB   = 4'b1000
    } fe_state_t;

endpackage

// File: rtl/safecrackpro_sync2.sv
// safecrackpro_sync2: parameterised-width two-flop synchronizer.
//   clk   in  1  destination clock
//   rst_n in  1  asynchronous active-low reset, both flops load RST_VAL
//   d     in  W  asynchronous input levels
//   q     out W  synchronized levels, two clk edges behind d
module safecrackpro_sync2 #(
    parameter int          W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/safecrackpro_btn_frontend.sv
// safecrackpro_btn_frontend: turns raw board keys into one single-cycle btn code per physical press.
//   clk         in  1      system clock
//   rst_n       in  1      asynchronous active-low reset
//   btn_raw     in  N_BTN  raw asynchronous key levels
//   btn         out N_BTN  accepted code for exactly one cycle per press, 0 otherwise
//   pressed     out 1      high from the accept cycle until the release is accepted
//   press_count out 8      accepted presses, wraps 255 -> 0
module safecrackpro_btn_frontend #(
    parameter int N_BTN           = safecrackpro_pkg::N_BTN,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn,
    output logic             pressed,
    output logic [7:0]       press_count
);

    import safecrackpro_pkg::*;

    localparam int               CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released key; the synchronizer resets to it so reset never looks like a press.
    localparam logic [N_BTN-1:0] RAW_IDLE = BTN_ACTIVE_LOW ? {N_BTN{1'b1}} : '0;

    logic [N_BTN-1:0] raw_s;
    logic [N_BTN-1:0] s;
    logic [N_BTN-1:0] cand;
    logic [N_BTN-1:0] cand_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    fe_state_t        state;
    fe_state_t        state_n;
    logic             accept;

    safecrackpro_sync2 #(
        .W      (N_BTN),
        .RST_VAL(RAW_IDLE)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_raw),
        .q    (raw_s)
    );

    assign s = BTN_ACTIVE_LOW ? ~raw_s : raw_s;

    // The counter restarts on every state entry and on every change of s, so an
    // accept means s held one value for DEBOUNCE_CYCLES+1 consecutive samples.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (s != '0) begin
                    state_n = PRESS_DB;
                    cand_n  = s;
                end
            end
            PRESS_DB: begin
                // Release wins over count expiry: a glitch never becomes a pulse.
                if (s == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (s != cand) begin
                    cand_n = s;
                    cnt_n  = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                cnt_n = '0;
                if (s == '0) state_n = REL_DB;
            end
            REL_DB: begin
                if (s != '0) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            btn         <= '0;
            pressed     <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cand        <= cand_n;
            btn         <= accept ? cand : '0;
            pressed     <= (state_n == HELD) || (state_n == REL_DB);
            press_count <= press_count + 8'(accept);
        end
    end

endmodule

// File: tb/tb_safecrackpro_btn_frontend.sv
// tb_safecrackpro_btn_frontend: directed and random key stimulus against a run-length reference model.
module tb_safecrackpro_btn_frontend;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn;
    logic       pressed;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    safecrackpro_btn_frontend #(
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn        (btn),
        .pressed    (pressed),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: keys pass a two-sample delay; a press is accepted on the
    // (D+1)-th consecutive identical nonzero sample while released, a release on the
    // (D+1)-th consecutive zero sample while held.
    logic [3:0] m_q0, m_q1, m_s, m_prev, m_btn;
    logic [7:0] m_cnt;
    int         m_run;
    bit         m_held;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q0 = '0; m_q1 = '0; m_prev = '0; m_run = 0;
            m_held = 1'b0; m_btn = '0; m_cnt = '0;
        end else begin
            m_s  = m_q1;
            m_q1 = m_q0;
            m_q0 = ~btn_raw;
            m_run = (m_s == m_prev) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
            m_prev = m_s;
            m_btn = '0;
            if (!m_held && m_s != 0 && m_run == D + 1) begin
                m_held = 1'b1;
                m_btn  = m_s;
                m_cnt  = m_cnt + 8'd1;
            end else if (m_held && m_s == 0 && m_run == D + 1) begin
                m_held = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("btn", btn, m_btn);
        chk("pressed", pressed, m_held);
        chk("press_count", press_count, m_cnt);
        if (btn != 0) pulses++;
    end

    task automatic set_keys(input logic [3:0] v);
        @(posedge clk);
        #1 btn_raw = ~v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Count posedges until a pulse (want_btn) or until pressed drops; 99 if the bound expires.
    task automatic wait_edges(input bit want_btn, output int k);
        k = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (want_btn ? (btn != 0) : !pressed) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p0;
        logic [7:0] c0;
        logic [3:0] v;
        // Reset state
        rst_n = 1'b0;
        hold(3);
        #1;
        chk("reset_btn", btn, 0);
        chk("reset_pressed", pressed, 0);
        chk("reset_count", press_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold(4);
        // 1: clean press of 0111
        set_keys(4'b0111);
        wait_edges(1'b1, k);
        chk("t1_latency", k, 11);
        chk("t1_code", btn, 4'b0111);
        chk("t1_pressed", pressed, 1);
        chk("t1_count", press_count, 1);
        @(posedge clk);
        #1 chk("t1_single", btn, 0);
        hold(17);
        set_keys(4'b0000);
        wait_edges(1'b0, k);
        chk("t1_rel_latency", k, 11);
        hold(4);
        // 2: bounce then stable 0001
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            set_keys((i % 2 == 0) ? 4'b0001 : 4'b0000);
            hold(2);
        end
        chk("t2_no_bounce_pulse", pulses - p0, 0);
        set_keys(4'b0001);
        wait_edges(1'b1, k);
        chk("t2_latency", k, 11);
        chk("t2_code", btn, 4'b0001);
        hold(10);
        set_keys(4'b0000);
        hold(15);
        chk("t2_one_pulse", pulses - p0, 1);
        // 3: staggered combination
        p0 = pulses;
        set_keys(4'b0100);
        @(posedge clk);
        set_keys(4'b0101);
        wait_edges(1'b1, k);
        chk("t3_latency", k, 11);
        chk("t3_code", btn, 4'b0101);
        hold(10);
        set_keys(4'b0000);
        hold(15);
        chk("t3_one_pulse", pulses - p0, 1);
        // 4: glitch, then release bounce inside a held press
        p0 = pulses;
        c0 = press_count;
        set_keys(4'b1000);
        hold(4);
        set_keys(4'b0000);
        hold(15);
        chk("t4_glitch_pulses", pulses - p0, 0);
        chk("t4_glitch_count", press_count, c0);
        chk("t4_glitch_pressed", pressed, 0);
        set_keys(4'b0010);
        wait_edges(1'b1, k);
        hold(5);
        set_keys(4'b0000);
        hold(3);
        set_keys(4'b0010);
        hold(20);
        chk("t4_bounce_pulses", pulses - p0, 1);
        chk("t4_bounce_pressed", pressed, 1);
        set_keys(4'b0000);
        hold(15);
        chk("t4_released", pressed, 0);
        // 5: press_count wrap
        rst_n = 1'b0;
        hold(2);
        #1 rst_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 255; i++) begin
            set_keys(4'($urandom_range(1, 15)));
            hold(12);
            set_keys(4'b0000);
            hold(12);
        end
        chk("t5_count_255", press_count, 255);
        chk("t5_pulses_255", pulses - p0, 255);
        set_keys(4'b1111);
        hold(12);
        chk("t5_count_wrap", press_count, 0);
        chk("t5_pressed", pressed, 1);
        set_keys(4'b0000);
        hold(15);
        // 6: reset mid-HELD then mid-PRESS_DB with the key still down
        set_keys(4'b0011);
        wait_edges(1'b1, k);
        hold(3);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_held_rst_pressed", pressed, 0);
        chk("t6_held_rst_count", press_count, 0);
        hold(3);
        #1 rst_n = 1'b1;
        wait_edges(1'b1, k);
        chk("t6_held_latency", k, 11);
        chk("t6_held_code", btn, 4'b0011);
        chk("t6_held_count", press_count, 1);
        set_keys(4'b0000);
        hold(15);
        set_keys(4'b0011);
        hold(5);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_db_rst_btn", btn, 0);
        chk("t6_db_rst_pressed", pressed, 0);
        chk("t6_db_rst_count", press_count, 0);
        hold(2);
        #1 rst_n = 1'b1;
        wait_edges(1'b1, k);
        chk("t6_db_latency", k, 11);
        set_keys(4'b0000);
        hold(15);
        // Random key activity checked cycle by cycle against the model
        for (int i = 0; i < 120; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            set_keys(v);
            hold($urandom_range(0, 25));
        end
        set_keys(4'b0000);
        hold(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
